// File: rtl/instr_fetch.sv
// Instruction fetch unit: drives the instruction memory read port, buffers returned words
// with their PC in a small FIFO and hands them to decode over a valid/ready handshake.
module instr_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_instr_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW:0]   DEPTH_W   = (CW+1)'(FIFO_DEPTH);
   localparam logic [PW-1:0] LAST_SLOT = PW'(FIFO_DEPTH - 1);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t        fifo_q [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr_q;
   logic [PW-1:0] wr_ptr_q;
   logic [CW-1:0] count_q;
   logic [31:0]   pc_q;
   logic [31:0]   inflight_pc_q;
   logic          inflight_q;

   logic          pop;
   logic          push;
   logic [CW:0]   occupancy;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == LAST_SLOT) return '0;
      return p + PW'(1);
   endfunction

   // Handshake: a word transfers to decode on a cycle where instr_valid_o and instr_ready_i
   // are both high; valid never depends on ready, and the head stays stable until taken.
   assign instr_valid_o = (count_q != '0) & ~redirect_i & ~rst_i;
   assign pop           = instr_valid_o & instr_ready_i;
   assign push          = inflight_q & ~redirect_i & ~rst_i;

   // Slots still needed once this cycle's pop and returning word settle; issuing only while
   // this is below the depth guarantees every returning word has room.
   assign occupancy  = {1'b0, count_q} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, inflight_q};
   assign imem_req_o = ~rst_i & ~redirect_i & (occupancy < DEPTH_W);

   assign imem_addr_o = pc_q;
   assign instr_o     = fifo_q[rd_ptr_q].instr;
   assign instr_pc_o  = fifo_q[rd_ptr_q].pc;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q          <= RESET_PC & 32'hFFFF_FFFC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         count_q       <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      end else if (redirect_i) begin
         // Flush queued words and forget the in-flight one; the head register keeps its data.
         pc_q       <= redirect_pc_i & 32'hFFFF_FFFC;
         inflight_q <= 1'b0;
         count_q    <= '0;
         wr_ptr_q   <= rd_ptr_q;
      end else begin
         inflight_q <= imem_req_o;
         if (imem_req_o) begin
            pc_q          <= pc_q + 32'd4;
            inflight_pc_q <= pc_q;
         end
         if (push) begin
            fifo_q[wr_ptr_q] <= '{pc: inflight_pc_q, instr: imem_instr_i};
            wr_ptr_q         <= ptr_inc(wr_ptr_q);
         end
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: cycle-by-cycle vector table plus a handshake scoreboard, with a
// 1-cycle synchronous instruction memory model.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] exp_q[$];

   typedef struct {
      logic        rst;
      logic        redir;
      logic [31:0] rpc;
      logic        rdy;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .imem_req_o   (imem_req),
      .imem_addr_o  (imem_addr),
      .imem_instr_i (imem_instr),
      .redirect_i   (redirect),
      .redirect_pc_i(redirect_pc),
      .instr_valid_o(instr_valid),
      .instr_ready_i(instr_ready),
      .instr_o      (instr),
      .instr_pc_o   (instr_pc)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h0150_0093;
         32'h0000_0004: return 32'h0070_0113;
         32'h0000_0008: return 32'h0020_81B3;
         32'h0000_003C: return 32'h0040_0CEF;
         default:       return ~a;
      endcase
   endfunction

   // Memory: data for a request appears the following cycle; garbage otherwise.
   always @(posedge clk) begin
      if (imem_req) imem_instr <= mem_word(imem_addr);
      else          imem_instr <= 32'hBAD0_BAD0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: every handshake must match the oldest expected {pc, instr}.
   always @(negedge clk) begin
      if (!rst && instr_valid && instr_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: handshake pc %h instr %h, expected none", instr_pc, instr);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("sb_pc", instr_pc, e[63:32]);
            chk("sb_instr", instr, e[31:0]);
         end
      end
   end

   function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] rp,
                               input logic rdy, input logic eq, input logic [31:0] ea,
                               input logic ev, input logic [31:0] ep);
      vec_t v;
      v.rst = r; v.redir = rd; v.rpc = rp; v.rdy = rdy;
      v.e_req = eq; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
      return v;
   endfunction

   task automatic apply(input int idx, input vec_t v);
      @(posedge clk);
      #1;
      rst         = v.rst;
      redirect    = v.redir;
      redirect_pc = v.rpc;
      instr_ready = v.rdy;
      if (v.e_valid && v.rdy && !v.redir && !v.rst)
         exp_q.push_back({v.e_pc, mem_word(v.e_pc)});
      @(negedge clk);
      chk($sformatf("row%0d req", idx), {31'b0, imem_req}, {31'b0, v.e_req});
      if (v.e_req) chk($sformatf("row%0d addr", idx), imem_addr, v.e_addr);
      chk($sformatf("row%0d valid", idx), {31'b0, instr_valid}, {31'b0, v.e_valid});
      if (v.e_valid) begin
         chk($sformatf("row%0d pc", idx), instr_pc, v.e_pc);
         chk($sformatf("row%0d instr", idx), instr, mem_word(v.e_pc));
      end
   endtask

   initial begin
      rst         = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      instr_ready = 1'b0;

      // Streaming from reset with decode always ready.
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0004));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0008));
      // Re-reset, then stall decode for 6 cycles: two entries fill, requests stop.
      vecs.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0004, 1'b0, 32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000));
      // Release: 0x0, 0x4, 0x8 in order.
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0004));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0008));
      // Redirect to 0x3F with a word queued and a fetch in flight.
      vecs.push_back(mk(1'b0, 1'b1, 32'h0000_003F, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_003C, 1'b0, 32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0040, 1'b0, 32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0044, 1'b1, 32'h0000_003C));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0048, 1'b1, 32'h0000_0040));
      // Fill the FIFO, then redirect to 0xFFFFFFFC with ready high: no handshake, wrap to 0.
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0044));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0044));
      vecs.push_back(mk(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000));
      // Back-to-back redirects: the second target wins.
      vecs.push_back(mk(1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0));
      vecs.push_back(mk(1'b0, 1'b1, 32'h0000_0202, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0204, 1'b0, 32'h0));
      vecs.push_back(mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0208, 1'b1, 32'h0000_0200));

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset req", {31'b0, imem_req}, 32'h0);
      chk("reset valid", {31'b0, instr_valid}, 32'h0);
      chk("reset instr", instr, 32'h0);
      chk("reset instr_pc", instr_pc, 32'h0);

      for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

      // Mid-stream reset for one cycle while a fetch is in flight.
      apply(100, mk(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0));
      apply(101, mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0));
      apply(102, mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0));
      apply(103, mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000));

      @(posedge clk);
      #1;
      chk("sb_drained", exp_q.size(), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
